grid_renderer: RTL and testbench

Parametrised pixel generator for the Tetris playfield and next-block preview. It uses per-line cell sequencers instead of hard-wired coordinate windows, and renders a 2-bit colour code per cell through a palette. Cleared rows blink under a frame counter. It sits between the game-area register file and the VGA pixel mux; its `dav` marks pixels that override the background.

---
 rtl/grid_renderer_if.sv | 32 +++
 rtl/grid_renderer.sv | 249 ++++++++++++++++++++++++
 tb/tb_grid_renderer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/grid_renderer_if.sv
// Bus between VGA timing / game-area register file and the grid renderer.
// The master drives pixel position and cell data; the slave returns row address and pixel.
interface grid_renderer_if #(
    parameter int unsigned COLS  = 12,
    parameter int unsigned ROWS  = 20,
    parameter int unsigned PCOLS = 4,
    parameter int unsigned PROWS = 2
);
    localparam int unsigned RAW = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic [10:0]            x;
    logic [9:0]             y;
    logic [RAW-1:0]         row_addr;
    logic [2*COLS-1:0]      row_data;
    logic [ROWS-1:0]        clear_rows;
    logic                   preview_en;
    logic [PCOLS*PROWS-1:0] preview_data;
    logic [1:0]             r;
    logic [1:0]             g;
    logic [1:0]             b;
    logic                   dav;

    modport master (
        output x, y, row_data, clear_rows, preview_en, preview_data,
        input  row_addr, r, g, b, dav
    );

    modport slave (
        input  x, y, row_data, clear_rows, preview_en, preview_data,
        output row_addr, r, g, b, dav
    );
endinterface

// File: rtl/grid_renderer.sv
// Tetris playfield and next-block preview pixel generator: per-line cell sequencers,
// 2-bit palette colours and blinking of rows pending clear. Two-cycle registered pipeline.
module grid_renderer #(
    parameter int unsigned COLS         = 12,
    parameter int unsigned ROWS         = 20,
    parameter int unsigned CELL         = 18,
    parameter int unsigned GAP          = 3,
    parameter int unsigned X0           = 140,
    parameter int unsigned Y0           = 129,
    parameter int unsigned PCOLS        = 4,
    parameter int unsigned PROWS        = 2,
    parameter int unsigned PX0          = 492,
    parameter int unsigned PY0          = 272,
    parameter logic [23:0] PALETTE      = 24'hFFF_FFF,
    parameter int unsigned BLINK_FRAMES = 16
) (
    input  logic           vga_clk,
    input  logic           rst,
    grid_renderer_if.slave bus
);
    localparam int unsigned PITCH = CELL + GAP;
    localparam int unsigned RAW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned PRW   = (PROWS > 1) ? $clog2(PROWS) : 1;
    localparam int unsigned CW    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned PCOLW = (PCOLS > 1) ? $clog2(PCOLS) : 1;
    localparam int unsigned PMAX  = (CELL > GAP) ? CELL : GAP;
    localparam int unsigned PXW   = (PMAX > 1) ? $clog2(PMAX) : 1;
    localparam int unsigned FCW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    typedef enum logic [1:0] {H_WAIT, H_CELL, H_GAP, H_DONE} hstate_e;

    function automatic logic [5:0] pal(input logic [1:0] code);
        case (code)
            2'd1:    pal = PALETTE[11:6];
            2'd2:    pal = PALETTE[17:12];
            2'd3:    pal = PALETTE[23:18];
            default: pal = PALETTE[5:0];
        endcase
    endfunction

    logic line_start_c;
    logic frame_start_c;
    assign line_start_c  = (bus.x == '0);
    assign frame_start_c = line_start_c && (bus.y == '0);

    // Which cell row (if any) the current line falls in, for both regions
    logic           pf_hit_c;
    logic [RAW-1:0] pf_row_c;
    logic           pv_hit_c;
    logic [PRW-1:0] pv_row_c;

    always_comb begin
        pf_hit_c = 1'b0;
        pf_row_c = '0;
        pv_hit_c = 1'b0;
        pv_row_c = '0;
        for (int unsigned n = 0; n < ROWS; n++) begin
            if (32'(bus.y) >= Y0 + n*PITCH && 32'(bus.y) < Y0 + n*PITCH + CELL) begin
                pf_hit_c = 1'b1;
                pf_row_c = RAW'(n);
            end
        end
        for (int unsigned n = 0; n < PROWS; n++) begin
            if (32'(bus.y) >= PY0 + n*PITCH && 32'(bus.y) < PY0 + n*PITCH + CELL) begin
                pv_hit_c = 1'b1;
                pv_row_c = PRW'(n);
            end
        end
    end

    logic [RAW-1:0]  row_addr_q;
    logic            v_valid_q;
    logic [PRW-1:0]  pv_row_q;
    logic            pv_valid_q;
    logic [FCW-1:0]  frame_cnt_q;
    logic            blink_q;
    logic [ROWS-1:0] clr_q;

    // Vertical sequencers re-arm at each line start; blink state advances at frame start
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            row_addr_q  <= '0;
            v_valid_q   <= 1'b0;
            pv_row_q    <= '0;
            pv_valid_q  <= 1'b0;
            frame_cnt_q <= '0;
            blink_q     <= 1'b0;
            clr_q       <= '0;
        end else begin
            if (line_start_c) begin
                v_valid_q  <= pf_hit_c;
                pv_valid_q <= pv_hit_c;
                if (pf_hit_c) row_addr_q <= pf_row_c;
                if (pv_hit_c) pv_row_q <= pv_row_c;
            end
            if (frame_start_c) begin
                clr_q <= bus.clear_rows;
                if (frame_cnt_q == FCW'(BLINK_FRAMES - 1)) begin
                    frame_cnt_q <= '0;
                    blink_q     <= ~blink_q;
                end else begin
                    frame_cnt_q <= frame_cnt_q + FCW'(1);
                end
            end
        end
    end

    hstate_e        pf_st_q;
    logic [PXW-1:0] pf_pix_q;
    logic [CW-1:0]  pf_col_q;

    // Playfield horizontal sequencer; state describes the pixel captured this edge
    always_ff @(posedge vga_clk) begin
        if (rst || line_start_c) begin
            pf_st_q  <= H_WAIT;
            pf_pix_q <= '0;
            pf_col_q <= '0;
        end else begin
            case (pf_st_q)
                H_WAIT: begin
                    if (bus.x == 11'(X0)) begin
                        pf_st_q  <= H_CELL;
                        pf_pix_q <= '0;
                        pf_col_q <= '0;
                    end
                end
                H_CELL: begin
                    if (pf_pix_q == PXW'(CELL - 1)) begin
                        pf_pix_q <= '0;
                        pf_st_q  <= (pf_col_q == CW'(COLS - 1)) ? H_DONE : H_GAP;
                    end else begin
                        pf_pix_q <= pf_pix_q + PXW'(1);
                    end
                end
                H_GAP: begin
                    if (pf_pix_q == PXW'(GAP - 1)) begin
                        pf_pix_q <= '0;
                        pf_col_q <= pf_col_q + CW'(1);
                        pf_st_q  <= H_CELL;
                    end else begin
                        pf_pix_q <= pf_pix_q + PXW'(1);
                    end
                end
                H_DONE:  pf_st_q <= H_DONE;
                default: pf_st_q <= H_WAIT;
            endcase
        end
    end

    hstate_e          pv_st_q;
    logic [PXW-1:0]   pv_pix_q;
    logic [PCOLW-1:0] pv_col_q;

    // Preview horizontal sequencer, same walk against PX0/PCOLS
    always_ff @(posedge vga_clk) begin
        if (rst || line_start_c) begin
            pv_st_q  <= H_WAIT;
            pv_pix_q <= '0;
            pv_col_q <= '0;
        end else begin
            case (pv_st_q)
                H_WAIT: begin
                    if (bus.x == 11'(PX0)) begin
                        pv_st_q  <= H_CELL;
                        pv_pix_q <= '0;
                        pv_col_q <= '0;
                    end
                end
                H_CELL: begin
                    if (pv_pix_q == PXW'(CELL - 1)) begin
                        pv_pix_q <= '0;
                        pv_st_q  <= (pv_col_q == PCOLW'(PCOLS - 1)) ? H_DONE : H_GAP;
                    end else begin
                        pv_pix_q <= pv_pix_q + PXW'(1);
                    end
                end
                H_GAP: begin
                    if (pv_pix_q == PXW'(GAP - 1)) begin
                        pv_pix_q <= '0;
                        pv_col_q <= pv_col_q + PCOLW'(1);
                        pv_st_q  <= H_CELL;
                    end else begin
                        pv_pix_q <= pv_pix_q + PXW'(1);
                    end
                end
                H_DONE:  pv_st_q <= H_DONE;
                default: pv_st_q <= H_WAIT;
            endcase
        end
    end

    logic [1:0] code_c;
    logic       occ_c;
    logic       clr_row_c;

    // Select the current cell's code and preview occupancy bit
    always_comb begin
        code_c = 2'b00;
        for (int unsigned c = 0; c < COLS; c++) begin
            if (pf_col_q == CW'(c)) code_c = bus.row_data[2*(COLS-1-c) +: 2];
        end
        occ_c = 1'b0;
        for (int unsigned r = 0; r < PROWS; r++) begin
            for (int unsigned c = 0; c < PCOLS; c++) begin
                if (pv_row_q == PRW'(r) && pv_col_q == PCOLW'(c))
                    occ_c = bus.preview_data[r*PCOLS + PCOLS - 1 - c];
            end
        end
        clr_row_c = clr_q[row_addr_q];
    end

    logic [5:0] rgb_d, rgb_q;
    logic       dav_d, dav_q;

    // Pixel colour; playfield wins over preview, colour holds while nothing is drawn
    always_comb begin
        dav_d = 1'b0;
        rgb_d = rgb_q;
        if (pf_st_q == H_CELL && v_valid_q) begin
            if (blink_q && clr_row_c) begin
                dav_d = 1'b1;
                rgb_d = pal(2'd3);
            end else if (code_c != 2'b00) begin
                dav_d = 1'b1;
                rgb_d = pal(code_c);
            end
        end
        if (!dav_d && pv_st_q == H_CELL && pv_valid_q && bus.preview_en && occ_c) begin
            dav_d = 1'b1;
            rgb_d = pal(2'd1);
        end
    end

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            rgb_q <= '0;
            dav_q <= 1'b0;
        end else begin
            rgb_q <= rgb_d;
            dav_q <= dav_d;
        end
    end

    assign bus.r        = rgb_q[5:4];
    assign bus.g        = rgb_q[3:2];
    assign bus.b        = rgb_q[1:0];
    assign bus.dav      = dav_q;
    assign bus.row_addr = row_addr_q;
endmodule

// File: tb/tb_grid_renderer.sv
// Directed bench for grid_renderer: line sweeps with hand-computed pixel windows,
// reset behaviour, last-cell boundaries, blink phases and preview occupancy.
module tb_grid_renderer;
    localparam int unsigned LINE = 800;
    localparam logic [23:0] PAL  = 24'hFC0_C3F;
    localparam logic [5:0]  C1   = 6'b110000;
    localparam logic [5:0]  C2   = 6'b000000;
    localparam logic [5:0]  C3   = 6'b111111;

    logic vga_clk = 1'b0;
    logic rst;

    grid_renderer_if bus ();

    grid_renderer #(
        .PALETTE     (PAL),
        .BLINK_FRAMES(2)
    ) dut (
        .vga_clk(vga_clk),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 vga_clk = ~vga_clk;

    // Register-file model: data follows row_addr by one cycle
    logic [23:0] mem [20];
    always @(posedge vga_clk) bus.row_data <= mem[bus.row_addr];

    int n_checks = 0;
    int n_fail   = 0;

    logic       dav_l [LINE];
    logic [5:0] rgb_l [LINE];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    // Drive one full line; pixel j's output is captured two edges after it is presented
    task automatic sweep(input int yy);
        bus.y = 10'(yy);
        for (int j = 0; j <= int'(LINE); j++) begin
            bus.x = (j < int'(LINE)) ? 11'(j) : 11'd0;
            tick();
            if (j > 0) begin
                dav_l[j-1] = bus.dav;
                rgb_l[j-1] = {bus.r, bus.g, bus.b};
            end
        end
    endtask

    task automatic frame_start();
        bus.x = 11'd0;
        bus.y = 10'd0;
        tick();
    endtask

    function automatic int cnt(input int lo, input int hi);
        int s;
        s = 0;
        for (int i = lo; i <= hi; i++) if (dav_l[i] === 1'b1) s++;
        return s;
    endfunction

    initial begin
        int seen;
        for (int i = 0; i < 20; i++) mem[i] = 24'h0;
        mem[3]           = 24'h555555;
        bus.x            = 11'd0;
        bus.y            = 10'd200;
        bus.clear_rows   = '0;
        bus.preview_en   = 1'b0;
        bus.preview_data = '0;
        rst              = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        // Reset mid-line at y=200 (row 3, all cells code 1)
        for (int j = 0; j < 150; j++) begin
            bus.x = 11'(j);
            tick();
        end
        check("pre_rst_dav", bus.dav, 1);
        rst = 1'b1;
        for (int j = 150; j < 153; j++) begin
            bus.x = 11'(j);
            tick();
        end
        check("rst_r", bus.r, 0);
        check("rst_g", bus.g, 0);
        check("rst_b", bus.b, 0);
        check("rst_dav", bus.dav, 0);
        check("rst_row_addr", bus.row_addr, 0);
        rst  = 1'b0;
        seen = 0;
        for (int j = 153; j <= int'(LINE) + 1; j++) begin
            bus.x = (j < int'(LINE)) ? 11'(j) : 11'(j - int'(LINE));
            tick();
            if (bus.dav === 1'b1) seen++;
        end
        check("rst_line_dav_cnt", seen, 0);
        sweep(200);
        check("rearm_cnt", cnt(0, LINE-1), 216);
        check("rearm_row_addr", bus.row_addr, 3);

        // Single cell at row 0, cell 0
        mem[3] = 24'h0;
        mem[0] = 24'h400000;
        sweep(129);
        check("single_row_addr", bus.row_addr, 0);
        check("single_cnt", cnt(0, LINE-1), 18);
        check("single_dav139", dav_l[139], 0);
        check("single_dav140", dav_l[140], 1);
        check("single_dav157", dav_l[157], 1);
        check("single_dav158", dav_l[158], 0);
        check("single_rgb140", rgb_l[140], C1);
        check("single_rgb_hold", rgb_l[200], C1);

        // Gap line, then row 1
        mem[0] = 24'h555555;
        mem[1] = 24'h555555;
        sweep(147);
        check("gap_cnt", cnt(0, LINE-1), 0);
        check("gap_row_addr", bus.row_addr, 0);
        sweep(150);
        check("row1_row_addr", bus.row_addr, 1);
        check("row1_cnt", cnt(0, LINE-1), 216);
        check("row1_dav158", dav_l[158], 0);
        check("row1_dav161", dav_l[161], 1);

        // Last cell: row 19, cell 11, code 2
        mem[0]  = 24'h0;
        mem[1]  = 24'h0;
        mem[19] = 24'h000002;
        sweep(528);
        check("last_row_addr", bus.row_addr, 19);
        check("last_cnt528", cnt(0, LINE-1), 18);
        check("last_dav370", dav_l[370], 0);
        check("last_dav371", dav_l[371], 1);
        check("last_dav388", dav_l[388], 1);
        check("last_dav389", dav_l[389], 0);
        check("last_rgb371", rgb_l[371], C2);
        sweep(545);
        check("last_cnt545", cnt(371, 388), 18);
        sweep(546);
        check("last_cnt546", cnt(0, LINE-1), 0);

        // Blink on row 5; reset mid-frame first
        mem[19]        = 24'h0;
        bus.clear_rows = 20'h00020;
        bus.y          = 10'd300;
        tick();
        bus.x = 11'd5;
        rst   = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        for (int f = 0; f < 7; f++) begin
            if (f > 0) frame_start();
            if (f == 3) bus.clear_rows = '0;
            sweep(234);
            check($sformatf("blink_f%0d_cnt", f), cnt(0, LINE-1), (f == 2 || f == 3) ? 216 : 0);
            if (f == 2) begin
                check("blink_dav140", dav_l[140], 1);
                check("blink_dav157", dav_l[157], 1);
                check("blink_dav158", dav_l[158], 0);
                check("blink_rgb140", rgb_l[140], C3);
                sweep(255);
                check("blink_row6_cnt", cnt(0, LINE-1), 0);
            end
            if (f == 3) begin
                sweep(251);
                check("blink_f3_y251_cnt", cnt(0, LINE-1), 216);
            end
        end

        // Preview 8'h96
        bus.preview_data = 8'h96;
        bus.preview_en   = 1'b1;
        sweep(272);
        check("pv0_cnt", cnt(0, LINE-1), 36);
        check("pv0_dav512", dav_l[512], 0);
        check("pv0_dav513", dav_l[513], 1);
        check("pv0_dav530", dav_l[530], 1);
        check("pv0_dav531", dav_l[531], 0);
        check("pv0_dav534", dav_l[534], 1);
        check("pv0_dav551", dav_l[551], 1);
        check("pv0_dav552", dav_l[552], 0);
        check("pv0_rgb513", rgb_l[513], C1);
        sweep(289);
        check("pv0_y289_cnt", cnt(513, 551), 36);
        sweep(290);
        check("pv_gap_cnt", cnt(0, LINE-1), 0);
        sweep(293);
        check("pv1_cnt", cnt(0, LINE-1), 36);
        check("pv1_dav491", dav_l[491], 0);
        check("pv1_dav492", dav_l[492], 1);
        check("pv1_dav509", dav_l[509], 1);
        check("pv1_dav510", dav_l[510], 0);
        check("pv1_dav555", dav_l[555], 1);
        check("pv1_dav572", dav_l[572], 1);
        check("pv1_dav573", dav_l[573], 0);
        bus.preview_en = 1'b0;
        sweep(272);
        check("pv_off_cnt", cnt(0, LINE-1), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
